// File: rtl/mem_io_responder_pkg.sv
// Shared constants for the memory/IO responder: I/O map, select pattern, widths.
package mem_io_responder_pkg;

  localparam int          BYTE_W      = 8;
  localparam int          DEF_RAM_AW  = 17;

  localparam logic [17:0] IO_IN_OUT   = 18'h30000;
  localparam logic [17:0] IO_CLK_STOP = 18'h30004;
  localparam logic [1:0]  IO_SEL      = 2'b11;

  // Byte offsets inside the I/O window; snap bytes follow the counter byte.
  localparam logic [2:0]  OFF_IN_OUT   = IO_IN_OUT[2:0];
  localparam logic [2:0]  OFF_CLK_STOP = IO_CLK_STOP[2:0];
  localparam logic [2:0]  OFF_SNAP1    = OFF_CLK_STOP + 3'd1;
  localparam logic [2:0]  OFF_SNAP2    = OFF_CLK_STOP + 3'd2;
  localparam logic [2:0]  OFF_SNAP3    = OFF_CLK_STOP + 3'd3;

  function automatic logic is_io(input logic [17:0] addr);
    return addr[17:16] == IO_SEL;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Synchronous FIFO with registered occupancy; dout shows the head, 0 when empty.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int AW = 4,
  parameter int DW = BYTE_W
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: RAM plus rx/tx byte streams, cycle counter and stop flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW  = DEF_RAM_AW,
  parameter int FIFO_AW = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop
);

  logic [7:0]  ram [2**RAM_AW];
  logic [7:0]  ram_q;
  logic [7:0]  io_q;
  logic        rd_is_ram;
  logic [31:0] cnt;
  logic [31:0] snap;

  logic        io_sel;
  logic [2:0]  io_off;
  logic        io_rd;
  logic        io_wr;
  logic [7:0]  io_rdata;

  logic        rx_full, rx_empty, rx_pop;
  logic [7:0]  rx_dout;
  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic [7:0]  tx_din;
  logic        stop_wr;
  logic        snap_ld;

  logic        unused_addr;
  assign unused_addr = ^mem_a[31:18];

  // A full tx FIFO is the only reason to stall, so a commit never sees a refused push.
  assign rdy_out  = !tx_full;
  assign io_sel   = is_io(mem_a[17:0]);
  assign io_off   = mem_a[2:0];
  assign io_rd    = rdy_out && io_sel && !mem_wr;
  assign io_wr    = rdy_out && io_sel && mem_wr;

  assign rx_ready = !rx_full;
  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign mem_din  = rd_is_ram ? ram_q : io_q;

  always_comb begin
    rx_pop  = 1'b0;
    tx_push = 1'b0;
    tx_din  = mem_dout;
    stop_wr = 1'b0;
    snap_ld = 1'b0;
    if (io_rd && io_off == OFF_IN_OUT && !rx_empty) rx_pop = 1'b1;
    if (io_rd && io_off == OFF_CLK_STOP) snap_ld = 1'b1;
    if (io_wr && io_off == OFF_IN_OUT && mem_dout != 8'h00) tx_push = 1'b1;
    if (io_wr && io_off == OFF_CLK_STOP && !program_stop) begin
      stop_wr = 1'b1;
      tx_push = 1'b1;
      tx_din  = 8'h00;
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      OFF_IN_OUT:   io_rdata = rx_dout;
      OFF_CLK_STOP: io_rdata = cnt[7:0];
      OFF_SNAP1:    io_rdata = snap[15:8];
      OFF_SNAP2:    io_rdata = snap[23:16];
      OFF_SNAP3:    io_rdata = snap[31:24];
      default:      io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rdy_out && !io_sel) begin
      if (mem_wr) ram[mem_a[RAM_AW-1:0]] <= mem_dout;
      else        ram_q <= ram[mem_a[RAM_AW-1:0]];
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_is_ram    <= 1'b0;
      io_q         <= 8'h00;
      cnt          <= 32'd0;
      snap         <= 32'd0;
      program_stop <= 1'b0;
    end else begin
      if (rdy_out && !mem_wr) rd_is_ram <= !io_sel;
      if (io_rd)              io_q <= io_rdata;
      if (!program_stop)      cnt <= cnt + 32'd1;
      if (snap_ld)            snap <= cnt;
      if (stop_wr)            program_stop <= 1'b1;
    end
  end

  byte_fifo #(.AW(FIFO_AW), .DW(BYTE_W)) u_rx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (rx_valid && rx_ready),
    .din    (rx_data),
    .pop    (rx_pop),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty)
  );

  byte_fifo #(.AW(FIFO_AW), .DW(BYTE_W)) u_tx_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (tx_push),
    .din    (tx_din),
    .pop    (tx_pop),
    .dout   (tx_data),
    .full   (tx_full),
    .empty  (tx_empty)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Scoreboard bench for mem_io_responder: directed bus, rx and tx traffic.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;

  int          tests = 0;
  int          fails = 0;
  logic [7:0]  rd_exp[$];
  logic [7:0]  tx_exp[$];
  logic        tb_rd = 1'b0;
  logic        rd_pend = 1'b0;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mem_a        (mem_a),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .rdy_out      (rdy_out),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .program_stop (program_stop)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a read committed in one cycle is checked on mem_din in the next.
  always @(negedge clk_in) begin
    if (rd_pend) begin
      if (rd_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got 0x%0h with no read outstanding", mem_din);
      end else begin
        chk("mem_din", {24'd0, mem_din}, {24'd0, rd_exp.pop_front()});
      end
    end
    rd_pend = tb_rd && rdy_out && rst_in;
    if (tx_valid && tx_ready && rst_in) begin
      if (tx_exp.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL tx_unexpected: got 0x%0h with no byte expected", tx_data);
      end else begin
        chk("tx_data", {24'd0, tx_data}, {24'd0, tx_exp.pop_front()});
      end
    end
  end

  task automatic idle_bus();
    mem_a    = 32'h0003_0001;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
    tb_rd    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    idle_bus();
    step(n);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    mem_a    = a;
    mem_wr   = 1'b1;
    mem_dout = d;
    tb_rd    = 1'b0;
    step(1);
    idle_bus();
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] exp);
    rd_exp.push_back(exp);
    mem_a  = a;
    mem_wr = 1'b0;
    tb_rd  = 1'b1;
    step(1);
    idle_bus();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_din"},      {24'd0, mem_din}, 32'h00);
    chk({tag, "_rdy_out"},      {31'd0, rdy_out}, 32'h1);
    chk({tag, "_rx_ready"},     {31'd0, rx_ready}, 32'h1);
    chk({tag, "_tx_valid"},     {31'd0, tx_valid}, 32'h0);
    chk({tag, "_tx_data"},      {24'd0, tx_data}, 32'h00);
    chk({tag, "_program_stop"}, {31'd0, program_stop}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    idle_bus();

    #2 rst_in = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step(2);
    rst_in = 1'b1;

    // RAM round trip, top address and the bit-17 alias of RAM
    wr(32'h0000_0010, 8'hA5);
    chk("ram_pre_read", {24'd0, mem_din}, 32'h00);
    rd(32'h0000_0010, 8'hA5);
    wr(32'h0001_FFFF, 8'h5A);
    rd(32'h0001_FFFF, 8'h5A);
    rd(32'h0002_0010, 8'hA5);

    // rx stream
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    step(1);
    rx_data  = 8'h42;
    step(1);
    rx_valid = 1'b0;
    rd(32'h0003_0000, 8'h41);
    rd(32'h0003_0000, 8'h42);
    rd(32'h0003_0000, 8'h00);
    rx_valid = 1'b1;
    rx_data  = 8'h43;
    rd(32'h0003_0000, 8'h00);
    rx_valid = 1'b0;
    rd(32'h0003_0000, 8'h43);

    // tx stream, zero byte dropped
    tx_ready = 1'b1;
    tx_exp.push_back(8'h48);
    tx_exp.push_back(8'h69);
    wr(32'h0003_0000, 8'h00);
    wr(32'h0003_0000, 8'h48);
    wr(32'h0003_0000, 8'h69);
    idle(3);
    chk("tx_drained", {31'd0, tx_valid}, 32'h0);

    // stall on full tx FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_exp.push_back(8'(8'h11 + i));
      wr(32'h0003_0000, 8'(8'h11 + i));
      if (i == 14) chk("rdy_before_full", {31'd0, rdy_out}, 32'h1);
    end
    chk("rdy_after_16", {31'd0, rdy_out}, 32'h0);
    tx_exp.push_back(8'h99);
    mem_a    = 32'h0003_0000;
    mem_wr   = 1'b1;
    mem_dout = 8'h99;
    step(2);
    chk("rdy_held", {31'd0, rdy_out}, 32'h0);
    chk("tx_head_held", {24'd0, tx_data}, 32'h11);
    tx_ready = 1'b1;
    step(1);
    tx_ready = 1'b0;
    chk("rdy_rise", {31'd0, rdy_out}, 32'h1);
    step(1);
    idle_bus();
    chk("rdy_refull", {31'd0, rdy_out}, 32'h0);
    tx_ready = 1'b1;
    idle(20);
    chk("tx_stall_drained", {31'd0, tx_valid}, 32'h0);

    // counter snapshot at cycle 100 and cycle 300 after reset
    rst_in = 1'b0;
    #1;
    step(2);
    rst_in = 1'b1;
    idle(100);
    rd(32'h0003_0004, 8'h64);
    rd(32'h0003_0005, 8'h00);
    rd(32'h0003_0006, 8'h00);
    rd(32'h0003_0007, 8'h00);
    idle(196);
    rd(32'h0003_0004, 8'h2C);
    rd(32'h0003_0005, 8'h01);
    rd(32'h0003_0006, 8'h00);
    rd(32'h0003_0007, 8'h00);

    // stop in cycle 304: counter freezes at 305 (0x131), one 0x00 on tx
    tx_exp.push_back(8'h00);
    wr(32'h0003_0004, 8'hFF);
    chk("program_stop_set", {31'd0, program_stop}, 32'h1);
    wr(32'h0003_0004, 8'hFF);
    idle(10);
    chk("tx_stop_idle", {31'd0, tx_valid}, 32'h0);
    chk("tx_one_stop_byte", tx_exp.size(), 32'd0);
    rd(32'h0003_0004, 8'h31);
    rd(32'h0003_0005, 8'h01);
    idle(5);
    rd(32'h0003_0004, 8'h31);

    // asynchronous reset with live state
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h55);
    rd(32'h0000_0010, 8'hA5);
    @(negedge clk_in);
    #2;
    chk("pre_reset_tx_valid", {31'd0, tx_valid}, 32'h1);
    chk("pre_reset_stop", {31'd0, program_stop}, 32'h1);
    rst_in = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    chk("rd_queue_empty", rd_exp.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
